// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures period and high time of an async clock in
// clkin1 cycles and flags tolerance errors and a stopped clock.
// Ports: clkin1/pll_rst (async, active-low), en, clk_mon in;
//   period, high_time, meas_valid, in_range, clk_lost, err_cnt out.
module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 2500,
  parameter int EXP_HIGH   = 1250,
  parameter int TOL        = 4,
  parameter int TIMEOUT    = 8000
) (
  input  logic             clkin1,
  input  logic             pll_rst,
  input  logic             en,
  input  logic             clk_mon,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             clk_lost,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] H_MIN = CNT_W'(EXP_HIGH - TOL);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(EXP_HIGH + TOL);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_cap;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             rise;
  logic             fall;
  logic             edge_seen;
  logic             timeout;
  logic             meas;
  logic             p_ok;
  logic             h_ok;
  logic             err_inc;

  assign rise    = sync2 & ~hist;
  assign fall    = ~sync2 & hist;
  assign cnt_inc = cnt + CNT_W'(1);

  // An edge the current state acts on beats a timeout in the same cycle.
  // ">=" keeps the counter from running past the limit if a fall
  // arrives exactly on the last count.
  assign edge_seen = rise | ((state == S_HIGH) & fall);
  assign timeout   = en && (state != S_IDLE) &&
                     (cnt >= TO_LAST) && !edge_seen;
  assign meas      = en && (state == S_LOW) && rise;

  assign p_ok    = (cnt_inc >= P_MIN) && (cnt_inc <= P_MAX);
  assign h_ok    = (high_cap >= H_MIN) && (high_cap <= H_MAX);
  assign err_inc = timeout || (meas && !(p_ok && h_ok));

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= clk_mon;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      high_cap <= '0;
    end else if (!en) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else if (timeout) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      cnt <= rise ? '0 : cnt_inc;
      unique case (state)
        S_WAIT: if (rise) state <= S_HIGH;
        S_HIGH: if (fall) begin
          high_cap <= cnt_inc;
          state    <= S_LOW;
        end
        S_LOW:  if (rise) state <= S_HIGH;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      clk_lost   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      meas_valid <= meas;
      if (meas) begin
        period    <= cnt_inc;
        high_time <= high_cap;
        in_range  <= p_ok && h_ok;
        clk_lost  <= 1'b0;
      end
      if (timeout) begin
        clk_lost <= 1'b1;
        in_range <= 1'b0;
      end
      if (err_inc && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: directed vectors for clk_period_monitor.
// Table of monitored-clock cycles plus timeout/enable/reset sequences.
module tb_clk_period_monitor;

  logic        clkin1;
  logic        pll_rst;
  logic        en;
  logic        clk_mon;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        meas_valid;
  logic        in_range;
  logic        clk_lost;
  logic [7:0]  err_cnt;

  logic        en2;
  logic        clk_mon2;
  logic [15:0] period2;
  logic [15:0] high_time2;
  logic        meas_valid2;
  logic        in_range2;
  logic        clk_lost2;
  logic [7:0]  err_cnt2;

  clk_period_monitor dut (
    .clkin1     (clkin1),
    .pll_rst    (pll_rst),
    .en         (en),
    .clk_mon    (clk_mon),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .in_range   (in_range),
    .clk_lost   (clk_lost),
    .err_cnt    (err_cnt)
  );

  // Short-timeout instance so saturation is reachable quickly.
  clk_period_monitor #(
    .CNT_W(16), .EXP_PERIOD(8), .EXP_HIGH(4), .TOL(1), .TIMEOUT(16)
  ) u_sat (
    .clkin1     (clkin1),
    .pll_rst    (pll_rst),
    .en         (en2),
    .clk_mon    (clk_mon2),
    .period     (period2),
    .high_time  (high_time2),
    .meas_valid (meas_valid2),
    .in_range   (in_range2),
    .clk_lost   (clk_lost2),
    .err_cnt    (err_cnt2)
  );

  typedef struct {
    int h;
    int p;
    int e_period;
    int e_high;
    int e_in;
    int e_err;
  } vec_t;

  vec_t vecs[9];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int meas_n = 0;
  int mv_p[64];
  int mv_h[64];
  int mv_in[64];
  int mv_err[64];
  int mv_cyc[64];
  int mv_last;

  initial clkin1 = 1'b0;
  always #5 clkin1 = ~clkin1;

  always @(posedge clkin1) cyc++;

  always @(negedge clkin1) begin
    if (meas_valid && meas_n < 64) begin
      mv_p[meas_n]   = int'(period);
      mv_h[meas_n]   = int'(high_time);
      mv_in[meas_n]  = int'(in_range);
      mv_err[meas_n] = int'(err_cnt);
      mv_cyc[meas_n] = cyc;
      meas_n++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clkin1);
  endtask

  task automatic mon_wave(input int h, input int p);
    clk_mon = 1'b1;
    ticks(h);
    clk_mon = 1'b0;
    ticks(p - h);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clkin1);
  endtask

  initial begin
    vecs[0] = '{1249, 2500, 2500, 1249, 1, 0};
    vecs[1] = '{1249, 2500, 2500, 1249, 1, 0};
    vecs[2] = '{1250, 2504, 2504, 1250, 1, 0};
    vecs[3] = '{1250, 2505, 2505, 1250, 0, 1};
    vecs[4] = '{1246, 2500, 2500, 1246, 1, 1};
    vecs[5] = '{1245, 2500, 2500, 1245, 0, 2};
    vecs[6] = '{1250, 2495, 2495, 1250, 0, 3};
    vecs[7] = '{1254, 2500, 2500, 1254, 1, 3};
    vecs[8] = '{1250, 2496, 2496, 1250, 1, 3};

    pll_rst  = 1'b0;
    en       = 1'b0;
    clk_mon  = 1'b0;
    en2      = 1'b0;
    clk_mon2 = 1'b0;
    ticks(3);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_mv", int'(meas_valid), 0);
    check("rst_in_range", int'(in_range), 0);
    check("rst_lost", int'(clk_lost), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_err2", int'(err_cnt2), 0);
    pll_rst = 1'b1;
    ticks(1);
    en = 1'b1;
    ticks(2);

    // Table: first rise arms, each later rise measures the prior cycle.
    for (int i = 0; i < 9; i++) mon_wave(vecs[i].h, vecs[i].p);
    clk_mon = 1'b1;
    ticks(10);
    check("tbl_count", meas_n, 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tbl%0d_period", i), mv_p[i], vecs[i].e_period);
      check($sformatf("tbl%0d_high", i), mv_h[i], vecs[i].e_high);
      check($sformatf("tbl%0d_in", i), mv_in[i], vecs[i].e_in);
      check($sformatf("tbl%0d_err", i), mv_err[i], vecs[i].e_err);
      if (i > 0)
        check($sformatf("tbl%0d_spacing", i),
              mv_cyc[i] - mv_cyc[i-1], vecs[i].p);
    end

    // Stopped clock after the last in-range measurement.
    ticks(1240);
    clk_mon = 1'b0;
    mv_last = mv_cyc[8];
    wait_cyc(mv_last + 7999);
    check("pre_to_lost", int'(clk_lost), 0);
    check("pre_to_in", int'(in_range), 1);
    wait_cyc(mv_last + 8000);
    check("to1_lost", int'(clk_lost), 1);
    check("to1_in", int'(in_range), 0);
    check("to1_err", int'(err_cnt), 4);
    wait_cyc(mv_last + 15999);
    check("pre_to2_err", int'(err_cnt), 4);
    wait_cyc(mv_last + 16000);
    check("to2_err", int'(err_cnt), 5);
    check("to_no_mv", meas_n, 9);

    // Restart: rise arms, next rise measures and clears clk_lost.
    mon_wave(1249, 2500);
    mon_wave(1249, 2500);
    clk_mon = 1'b1;
    ticks(10);
    check("rs_count", meas_n, 11);
    check("rs_period", mv_p[9], 2500);
    check("rs_in", mv_in[9], 1);
    check("rs_err", mv_err[9], 5);
    check("rs_lost", int'(clk_lost), 0);

    // Drop en while in LOW; nothing measured, outputs hold.
    ticks(1239);
    clk_mon = 1'b0;
    ticks(500);
    en = 1'b0;
    ticks(751);
    mon_wave(1249, 2500);
    mon_wave(1249, 2495);
    check("dis_count", meas_n, 11);
    check("dis_period", int'(period), 2500);
    check("dis_high", int'(high_time), 1249);
    check("dis_in", int'(in_range), 1);
    check("dis_err", int'(err_cnt), 5);
    en = 1'b1;
    ticks(5);
    clk_mon = 1'b1;
    ticks(10);
    check("reen_rise1", meas_n, 11);
    ticks(1239);
    clk_mon = 1'b0;
    ticks(1251);
    clk_mon = 1'b1;
    ticks(10);
    check("reen_rise2", meas_n, 12);
    check("reen_period", mv_p[11], 2500);
    check("reen_high", mv_h[11], 1249);

    // Reset asserted mid-HIGH clears outputs at once.
    ticks(500);
    @(posedge clkin1);
    #2 pll_rst = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high", int'(high_time), 0);
    check("arst_in", int'(in_range), 0);
    check("arst_err", int'(err_cnt), 0);
    check("arst_lost", int'(clk_lost), 0);
    ticks(739);
    clk_mon = 1'b0;
    ticks(5);
    pll_rst = 1'b1;
    ticks(1246);
    mon_wave(1249, 2500);
    clk_mon = 1'b1;
    ticks(10);
    check("post_rst_count", meas_n, 13);
    check("post_rst_period", mv_p[12], 2500);
    check("post_rst_in", mv_in[12], 1);
    check("post_rst_err", mv_err[12], 0);

    // Saturation: >300 timeouts on the short-timeout instance.
    en2 = 1'b1;
    ticks(300 * 16 + 40);
    check("sat_err", int'(err_cnt2), 255);
    check("sat_lost", int'(clk_lost2), 1);
    check("sat_mv", int'(meas_valid2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
